// File: rtl/udp_rx_demux_pkg.sv
// Shared types and constants for the UDP receive demultiplexer.
package udp_rx_demux_pkg;

  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam int unsigned PORT_W        = 16;

  typedef enum logic [3:0] {
    ST_HDR     = 4'b0001,
    ST_PAYLOAD = 4'b0010,
    ST_PAD     = 4'b0100,
    ST_DROP    = 4'b1000
  } state_t;

  // Header byte offsets (big-endian fields); bytes 6..7 are the ignored checksum
  localparam logic [2:0] OFF_SRC_HI = 3'd0;
  localparam logic [2:0] OFF_SRC_LO = 3'd1;
  localparam logic [2:0] OFF_DST_HI = 3'd2;
  localparam logic [2:0] OFF_DST_LO = 3'd3;
  localparam logic [2:0] OFF_LEN_HI = 3'd4;
  localparam logic [2:0] OFF_LEN_LO = 3'd5;
  localparam logic [2:0] OFF_LAST   = 3'd7;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
  } udp_hdr_t;

  function automatic int unsigned dest_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udp_rx_demux_port_match.sv
// Destination-port lookup: lowest-index table entry equal to i_dst wins.
module udp_rx_demux_port_match
  import udp_rx_demux_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter logic [NUM_PORTS*PORT_W-1:0] PORT_LIST = {16'd5006, 16'd5005, 16'd5004, 16'd5003},
  localparam int unsigned DEST_W = dest_width(NUM_PORTS)
)(
  input  logic [PORT_W-1:0] i_dst,
  output logic              o_hit,
  output logic [DEST_W-1:0] o_idx
);

  // Scan high to low so the lowest matching index is written last
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (PORT_LIST[PORT_W*i +: PORT_W] == i_dst) begin
        o_hit = 1'b1;
        o_idx = DEST_W'(i);
      end
    end
  end

endmodule

// File: rtl/udp_rx_demux.sv
// UDP receive stage: parses the 8-byte header, filters on destination port and
// forwards the length-trimmed payload tagged with the matching channel.
module udp_rx_demux
  import udp_rx_demux_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter logic [NUM_PORTS*PORT_W-1:0] PORT_LIST = {16'd5006, 16'd5005, 16'd5004, 16'd5003},
  parameter int unsigned CNT_W = 16,
  localparam int unsigned DEST_W = dest_width(NUM_PORTS)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic [DEST_W-1:0] m_tdest,
  output logic              m_tuser,
  input  logic              m_tready,
  output logic [15:0]       src_port_out,
  output logic [15:0]       dst_port_out,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_t              r_state;
  logic [2:0]          r_hcnt;
  udp_hdr_t            r_hdr;
  logic [15:0]         r_rem;
  logic [DEST_W-1:0]   r_chan;

  logic                w_beat;
  logic                w_hit;
  logic [DEST_W-1:0]   w_idx;
  logic                w_len_short;
  logic                w_len_empty;
  logic                w_err_evt;
  logic                w_drop_evt;

  udp_rx_demux_port_match #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_LIST (PORT_LIST)
  ) u_match (
    .i_dst (r_hdr.dst),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

  // Only the payload state is throttled by the output register
  assign s_tready    = !reset && ((r_state != ST_PAYLOAD) || !m_tvalid || m_tready);
  assign w_beat      = s_tvalid && s_tready;
  assign w_len_short = r_hdr.len < 16'(UDP_HDR_BYTES);
  assign w_len_empty = r_hdr.len == 16'(UDP_HDR_BYTES);

  // One statistics event per datagram, decided at header end or truncation
  always_comb begin
    w_err_evt  = 1'b0;
    w_drop_evt = 1'b0;
    if (w_beat) begin
      case (r_state)
        ST_HDR: begin
          if (s_tlast)                       w_err_evt  = 1'b1;
          else if (r_hcnt == OFF_LAST) begin
            if (w_len_short)                 w_err_evt  = 1'b1;
            else if (w_len_empty || !w_hit)  w_drop_evt = 1'b1;
          end
        end
        ST_PAYLOAD: if (s_tlast && (r_rem != 16'd1)) w_err_evt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_HDR;
      r_hcnt       <= '0;
      r_hdr        <= '0;
      r_rem        <= '0;
      r_chan       <= '0;
      m_tdata      <= '0;
      m_tvalid     <= 1'b0;
      m_tlast      <= 1'b0;
      m_tdest      <= '0;
      m_tuser      <= 1'b0;
      src_port_out <= '0;
      dst_port_out <= '0;
      drop_cnt     <= '0;
      err_cnt      <= '0;
    end else begin
      if (m_tvalid && m_tready) m_tvalid <= 1'b0;

      case (r_state)
        ST_HDR: begin
          if (w_beat) begin
            case (r_hcnt)
              OFF_SRC_HI: r_hdr.src[15:8] <= s_tdata;
              OFF_SRC_LO: r_hdr.src[7:0]  <= s_tdata;
              OFF_DST_HI: r_hdr.dst[15:8] <= s_tdata;
              OFF_DST_LO: r_hdr.dst[7:0]  <= s_tdata;
              OFF_LEN_HI: r_hdr.len[15:8] <= s_tdata;
              OFF_LEN_LO: r_hdr.len[7:0]  <= s_tdata;
              default: ;
            endcase
            r_hcnt <= s_tlast ? 3'd0 : r_hcnt + 3'd1;
            if (r_hcnt == OFF_LAST) begin
              src_port_out <= r_hdr.src;
              dst_port_out <= r_hdr.dst;
              r_rem        <= (w_len_short || w_len_empty) ? 16'd0
                                                           : r_hdr.len - 16'(UDP_HDR_BYTES);
              r_chan       <= w_idx;
              if (!s_tlast)
                r_state <= (!w_len_short && !w_len_empty && w_hit) ? ST_PAYLOAD : ST_DROP;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_beat) begin
            m_tdata  <= s_tdata;
            m_tvalid <= 1'b1;
            m_tlast  <= (r_rem == 16'd1) || s_tlast;
            m_tuser  <= s_tlast && (r_rem != 16'd1);
            m_tdest  <= r_chan;
            r_rem    <= r_rem - 16'd1;
            if (r_rem == 16'd1) r_state <= s_tlast ? ST_HDR : ST_PAD;
            else if (s_tlast)   r_state <= ST_HDR;
          end
        end
        ST_PAD, ST_DROP: if (w_beat && s_tlast) r_state <= ST_HDR;
        default: r_state <= ST_HDR;
      endcase

      if (w_drop_evt && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      if (w_err_evt  && (err_cnt  != '1)) err_cnt  <= err_cnt  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_udp_rx_demux.sv
// Scoreboard bench for udp_rx_demux: a datagram model predicts payload beats and statistics.
module tb_udp_rx_demux;

  localparam int unsigned NP = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned DW = 2;
  // entry0=4000, entry1=5003, entry2=6000, entry3=5003 (duplicate, lower index wins)
  localparam logic [63:0] PLIST = {16'd5003, 16'd6000, 16'd5003, 16'd4000};

  typedef struct packed {
    logic [DW-1:0] dest;
    logic          user;
    logic          last;
    logic [7:0]    data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic [DW-1:0] m_tdest;
  logic          m_tuser;
  logic          m_tready;
  logic [15:0]   src_port_out;
  logic [15:0]   dst_port_out;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] err_cnt;

  beat_t         exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] exp_drop = '0;
  logic [CW-1:0] exp_err  = '0;
  logic [15:0]   exp_src  = '0;
  logic [15:0]   exp_dst  = '0;
  bit            rand_rdy = 1'b0;

  udp_rx_demux #(
    .NUM_PORTS (NP),
    .PORT_LIST (PLIST),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tdest      (m_tdest),
    .m_tuser      (m_tuser),
    .m_tready     (m_tready),
    .src_port_out (src_port_out),
    .dst_port_out (dst_port_out),
    .drop_cnt     (drop_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int find_port(input logic [15:0] dst);
    for (int i = 0; i < int'(NP); i++)
      if (PLIST[16*i +: 16] == dst) return i;
    return -1;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // Drive one byte and hold it until accepted; starts and ends 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b, input logic last);
    bit rdy;
    int guard;
    guard    = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    s_tlast  = last;
    do begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 2000);
    if (!rdy) check("s_tready_timeout", 32'(rdy), 32'd1);
  endtask

  // nwire = payload bytes on the wire; negative means the header itself is cut short
  task automatic send_frame(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                            input int nwire, input logic [7:0] seed);
    logic [7:0] f[$];
    int         total, ch, pl, n;
    beat_t      b;
    total = 8 + nwire;
    f.push_back(src[15:8]); f.push_back(src[7:0]);
    f.push_back(dst[15:8]); f.push_back(dst[7:0]);
    f.push_back(len[15:8]); f.push_back(len[7:0]);
    f.push_back(8'hAB);     f.push_back(8'hCD);
    while (f.size() > total) void'(f.pop_back());
    for (int k = 0; k < nwire; k++) f.push_back(8'(seed + k));

    if (total >= 8) begin
      exp_src = src;
      exp_dst = dst;
    end
    ch = find_port(dst);
    if (total <= 8 || len < 16'd8) exp_err = sat_inc(exp_err);
    else if (len == 16'd8 || ch < 0) exp_drop = sat_inc(exp_drop);
    else begin
      pl = int'(len) - 8;
      n  = (nwire < pl) ? nwire : pl;
      for (int k = 0; k < n; k++) begin
        b.dest = DW'(ch);
        b.last = (k == n - 1);
        b.user = (k == n - 1) && (nwire < pl);
        b.data = 8'(seed + k);
        exp_q.push_back(b);
      end
      if (nwire < pl) exp_err = sat_inc(exp_err);
    end

    foreach (f[i]) send_byte(f[i], i == f.size() - 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    check({tag, "_err_cnt"},  32'(err_cnt),  32'(exp_err));
    check({tag, "_src_port"}, 32'(src_port_out), 32'(exp_src));
    check({tag, "_dst_port"}, 32'(dst_port_out), 32'(exp_dst));
  endtask

  // Output monitor: every valid cycle must match the scoreboard head, so stalled data stays put
  always @(negedge clk) begin
    if (!reset && m_tvalid) begin
      if (exp_q.size() == 0) check("unexpected_beat", 32'(m_tvalid), 32'd0);
      else begin
        logic [11:0] e;
        e = exp_q[0];
        check("beat", 32'({m_tdest, m_tuser, m_tlast, m_tdata}), 32'(e));
        if (m_tready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_outputs",  32'({m_tdata, m_tlast, m_tuser, m_tdest}), 32'd0);
    check("rst_ports",    32'({src_port_out, dst_port_out}), 32'd0);
    check("rst_counters", 32'({drop_cnt, err_cnt}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_s_tready", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;

    // Basic match on entry 1 (entry 3 duplicates it)
    send_frame(16'd1111, 16'd5003, 16'd12, 4, 8'h01);
    drain_check("t1");

    // Padding beyond the UDP length, then a clean datagram on channel 0
    send_frame(16'd2222, 16'd6000, 16'd10, 4, 8'h40);
    send_frame(16'd2223, 16'd4000, 16'd11, 3, 8'h50);
    drain_check("t2");

    // Unmatched datagram followed back to back by a matched one
    send_frame(16'd3333, 16'd9999, 16'd20, 12, 8'h60);
    send_frame(16'd3334, 16'd5003, 16'd9, 1, 8'h70);
    drain_check("t3");

    // Truncated payload
    send_frame(16'd4444, 16'd5003, 16'd16, 3, 8'h80);
    drain_check("t4");

    // Long payload under random backpressure
    rand_rdy = 1'b1;
    send_frame(16'd5555, 16'd5003, 16'd264, 256, 8'h10);
    drain_check("t5");
    rand_rdy = 1'b0;

    // Empty and undersized lengths, truncated header, counter saturation
    send_frame(16'd6666, 16'd5003, 16'd8, 2, 8'h90);
    drain_check("t6_len8");
    send_frame(16'd6667, 16'd5003, 16'd4, 3, 8'hA0);
    drain_check("t6_len4");
    send_frame(16'd6668, 16'd5003, 16'd12, -3, 8'hB0);
    drain_check("t6_hdr_trunc");
    for (int r = 0; r < 3; r++) send_frame(16'(7000 + r), 16'd1234, 16'd10, 2, 8'hC0);
    drain_check("t6_drop_sat");
    send_frame(16'd7777, 16'd5003, 16'd12, -6, 8'hD0);
    drain_check("t6_err_sat");

    // Channel 2 still forwards after the counters have saturated
    send_frame(16'd8888, 16'd6000, 16'd13, 5, 8'hE0);
    drain_check("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
